// File: rtl/param_lifo.sv
// rtl/param_lifo.sv - parametrised register-array stack with registered pop output and sticky error flags
module param_lifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 32,
    parameter int AF_LEVEL = DEPTH - 2,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             PUSH,
    input  logic             POP,
    input  logic             CLR_ERR,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] DOUT,
    output logic             DOUT_VALID,
    output logic [WIDTH-1:0] TOP_DATA,
    output logic [CW-1:0]    COUNT,
    output logic             EMPTY,
    output logic             FULL,
    output logic             ALMOST_FULL,
    output logic             OVF,
    output logic             UDF
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] dout_q;
    logic             dout_valid_q;
    logic             ovf_q;
    logic             udf_q;

    logic             empty;
    logic             full;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;
    logic [WIDTH-1:0] top_word;
    logic             do_push;
    logic             do_pop;
    logic             do_replace;
    logic             do_pass;
    logic             ovf_evt;
    logic             udf_evt;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Index is pinned to 0 when empty so a non-power-of-two depth never reads past the array.
    assign top_idx  = empty ? '0 : AW'(count_q - CW'(1));
    assign top_word = mem[top_idx];

    assign do_push    = PUSH & ~POP & ~full;
    assign do_pop     = POP & ~PUSH & ~empty;
    assign do_replace = PUSH & POP & ~empty;
    assign do_pass    = PUSH & POP & empty;
    assign ovf_evt    = PUSH & ~POP & full;
    assign udf_evt    = POP & ~PUSH & empty;

    assign wr_idx = do_replace ? top_idx : AW'(count_q);

    always_ff @(posedge CLK) begin
        if (do_push || do_replace) begin
            mem[wr_idx] <= DIN;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
        end else begin
            dout_valid_q <= 1'b0;
            if (do_pop || do_replace) begin
                dout_q       <= top_word;
                dout_valid_q <= 1'b1;
            end else if (do_pass) begin
                dout_q       <= DIN;
                dout_valid_q <= 1'b1;
            end

            if (do_push) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop) begin
                count_q <= count_q - CW'(1);
            end

            // A fresh error in the same cycle as CLR_ERR keeps its flag set.
            ovf_q <= ovf_evt | (ovf_q & ~CLR_ERR);
            udf_q <= udf_evt | (udf_q & ~CLR_ERR);
        end
    end

    assign DOUT        = dout_q;
    assign DOUT_VALID  = dout_valid_q;
    assign TOP_DATA    = empty ? '0 : top_word;
    assign COUNT       = count_q;
    assign EMPTY       = empty;
    assign FULL        = full;
    assign ALMOST_FULL = (count_q >= CW'(AF_LEVEL));
    assign OVF         = ovf_q;
    assign UDF         = udf_q;

endmodule

// File: tb/tb_param_lifo.sv
// tb/tb_param_lifo.sv - directed bench for param_lifo with a behavioural stack model
module tb_param_lifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        push0 = 0, pop0 = 0, clr0 = 0;
    logic [7:0]  din0 = '0;
    logic [7:0]  dout0, top0;
    logic        dv0, empty0, full0, af0, ovf0, udf0;
    logic [2:0]  count0;

    logic        push1 = 0, pop1 = 0, clr1 = 0;
    logic [11:0] din1 = '0;
    logic [11:0] dout1, top1;
    logic        dv1, empty1, full1, af1, ovf1, udf1;
    logic [2:0]  count1;

    param_lifo #(.WIDTH(8), .DEPTH(4)) dut0 (
        .CLK(clk), .RESET(rst), .PUSH(push0), .POP(pop0), .CLR_ERR(clr0), .DIN(din0),
        .DOUT(dout0), .DOUT_VALID(dv0), .TOP_DATA(top0), .COUNT(count0),
        .EMPTY(empty0), .FULL(full0), .ALMOST_FULL(af0), .OVF(ovf0), .UDF(udf0)
    );

    param_lifo #(.WIDTH(12), .DEPTH(5)) dut1 (
        .CLK(clk), .RESET(rst), .PUSH(push1), .POP(pop1), .CLR_ERR(clr1), .DIN(din1),
        .DOUT(dout1), .DOUT_VALID(dv1), .TOP_DATA(top1), .COUNT(count1),
        .EMPTY(empty1), .FULL(full1), .ALMOST_FULL(af1), .OVF(ovf1), .UDF(udf1)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: stack contents as an array plus depth, and last popped word.
    int          dep [2] = '{4, 5};
    int          afl [2] = '{2, 3};
    logic [15:0] mm  [2][8];
    int          mc  [2];
    logic [15:0] md  [2];
    bit          mv  [2];
    bit          mo  [2];
    bit          mu  [2];

    task automatic model_step(input int k, input bit ps, input bit pp, input bit ce, input logic [15:0] d);
        bit eo, eu;
        eo = 0;
        eu = 0;
        mv[k] = 0;
        if (ps && pp) begin
            if (mc[k] == 0) md[k] = d;
            else begin
                md[k] = mm[k][mc[k]-1];
                mm[k][mc[k]-1] = d;
            end
            mv[k] = 1;
        end else if (ps) begin
            if (mc[k] == dep[k]) eo = 1;
            else begin
                mm[k][mc[k]] = d;
                mc[k]++;
            end
        end else if (pp) begin
            if (mc[k] == 0) eu = 1;
            else begin
                md[k] = mm[k][mc[k]-1];
                mv[k] = 1;
                mc[k]--;
            end
        end
        if (ce) begin
            mo[k] = 0;
            mu[k] = 0;
        end
        if (eo) mo[k] = 1;
        if (eu) mu[k] = 1;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                mc[k] = 0; md[k] = '0; mv[k] = 0; mo[k] = 0; mu[k] = 0;
            end
        end else begin
            model_step(0, push0, pop0, clr0, {8'h00, din0});
            model_step(1, push1, pop1, clr1, {4'h0, din1});
        end
    end

    function automatic logic [15:0] mtop(input int k);
        return (mc[k] == 0) ? 16'h0 : mm[k][mc[k]-1];
    endfunction

    bit started = 0;
    always @(negedge clk) begin
        if (started) begin
            chk("c0_dout",  32'(dout0),  32'(md[0][7:0]));
            chk("c0_valid", 32'(dv0),    32'(mv[0]));
            chk("c0_top",   32'(top0),   32'(mtop(0) & 16'h00FF));
            chk("c0_count", 32'(count0), 32'(mc[0]));
            chk("c0_empty", 32'(empty0), 32'(mc[0] == 0));
            chk("c0_full",  32'(full0),  32'(mc[0] == dep[0]));
            chk("c0_af",    32'(af0),    32'(mc[0] >= afl[0]));
            chk("c0_ovf",   32'(ovf0),   32'(mo[0]));
            chk("c0_udf",   32'(udf0),   32'(mu[0]));
            chk("c1_dout",  32'(dout1),  32'(md[1][11:0]));
            chk("c1_valid", 32'(dv1),    32'(mv[1]));
            chk("c1_top",   32'(top1),   32'(mtop(1) & 16'h0FFF));
            chk("c1_count", 32'(count1), 32'(mc[1]));
            chk("c1_empty", 32'(empty1), 32'(mc[1] == 0));
            chk("c1_full",  32'(full1),  32'(mc[1] == dep[1]));
            chk("c1_af",    32'(af1),    32'(mc[1] >= afl[1]));
            chk("c1_ovf",   32'(ovf1),   32'(mo[1]));
            chk("c1_udf",   32'(udf1),   32'(mu[1]));
        end
    end

    task automatic idle();
        push0 = 0; pop0 = 0; clr0 = 0;
        push1 = 0; pop1 = 0; clr1 = 0;
    endtask

    // One command on instance k for one clock; returns at the following negedge.
    task automatic cyc(input int k, input bit ps, input bit pp, input bit ce, input logic [15:0] d);
        #1;
        idle();
        if (k == 0) begin
            push0 = ps; pop0 = pp; clr0 = ce; din0 = d[7:0];
        end else begin
            push1 = ps; pop1 = pp; clr1 = ce; din1 = d[11:0];
        end
        @(negedge clk);
    endtask

    logic [7:0]  v0 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [11:0] v1 [5] = '{12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF};

    initial begin
        idle();
        #12 rst = 0;
        @(negedge clk);
        started = 1;
        chk("rst_count", 32'(count0), 0);
        chk("rst_empty", 32'(empty0), 1);
        chk("rst_dout",  32'(dout0),  0);
        chk("rst_top",   32'(top0),   0);

        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 0, 16'(v0[i]));
            chk("fill_count", 32'(count0), 32'(i + 1));
            chk("fill_af",    32'(af0),    32'(i >= 1));
            chk("fill_top",   32'(top0),   32'(v0[i]));
        end
        chk("fill_full", 32'(full0), 1);
        for (int i = 3; i >= 0; i--) begin
            cyc(0, 0, 1, 0, 16'h0);
            chk("drain_dout",  32'(dout0), 32'(v0[i]));
            chk("drain_valid", 32'(dv0),   1);
        end
        chk("drain_empty", 32'(empty0), 1);

        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 16'(v0[i]));
        cyc(0, 1, 0, 0, 16'h55);
        chk("ovf_count", 32'(count0), 4);
        chk("ovf_flag",  32'(ovf0),   1);
        chk("ovf_top",   32'(top0),   32'h44);
        cyc(0, 0, 0, 1, 16'h0);
        chk("ovf_clr",   32'(ovf0),   0);

        #1 idle();
        #1 rst = 1;
        #1 chk("rst2_dout", 32'(dout0), 0);
        #1 rst = 0;
        @(negedge clk);
        cyc(0, 0, 1, 0, 16'h0);
        chk("udf_flag",  32'(udf0),   1);
        chk("udf_valid", 32'(dv0),    0);
        chk("udf_dout",  32'(dout0),  0);
        chk("udf_count", 32'(count0), 0);
        cyc(0, 0, 1, 1, 16'h0);
        chk("udf_win",   32'(udf0),   1);
        cyc(0, 0, 0, 1, 16'h0);
        chk("udf_clr",   32'(udf0),   0);

        cyc(0, 1, 0, 0, 16'h11);
        cyc(0, 1, 0, 0, 16'h22);
        cyc(0, 1, 1, 0, 16'hAA);
        chk("rep_dout",  32'(dout0),  32'h22);
        chk("rep_count", 32'(count0), 2);
        chk("rep_top",   32'(top0),   32'hAA);
        cyc(0, 0, 1, 0, 16'h0);
        chk("rep_pop1",  32'(dout0),  32'hAA);
        cyc(0, 0, 1, 0, 16'h0);
        chk("rep_pop2",  32'(dout0),  32'h11);
        cyc(0, 1, 1, 0, 16'h5C);
        chk("pass_dout",  32'(dout0),  32'h5C);
        chk("pass_valid", 32'(dv0),    1);
        chk("pass_count", 32'(count0), 0);
        chk("pass_flags", 32'({ovf0, udf0}), 0);

        cyc(0, 1, 0, 0, 16'h01);
        cyc(0, 1, 0, 0, 16'h02);
        cyc(0, 1, 0, 0, 16'h03);
        chk("mid_count", 32'(count0), 3);
        #1 idle();
        #1 rst = 1;
        #1;
        chk("async_count", 32'(count0), 0);
        chk("async_empty", 32'(empty0), 1);
        chk("async_dout",  32'(dout0),  0);
        chk("async_top",   32'(top0),   0);
        #1 rst = 0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 16'(v1[i]));
        chk("d5_full",  32'(full1),  1);
        chk("d5_count", 32'(count1), 5);
        cyc(1, 1, 0, 0, 16'hFFF);
        chk("d5_ovf",   32'(ovf1),   1);
        chk("d5_cnt2",  32'(count1), 5);
        for (int i = 4; i >= 0; i--) begin
            cyc(1, 0, 1, 0, 16'h0);
            chk("d5_pop", 32'(dout1), 32'(v1[i]));
        end
        chk("d5_empty", 32'(empty1), 1);

        #1 idle();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
